// File: rtl/keypad_debouncer_if.sv
// rtl/keypad_debouncer_if.sv - keypad line and conditioned key output bundle
interface keypad_debouncer_if;
    logic [11:0] keys;
    logic [3:0]  button;
    logic        bstate;
    logic        readInput;
    logic        keyStrobe;
    logic        chordErr;

    modport master (
        output keys,
        input  button, bstate, readInput, keyStrobe, chordErr
    );

    modport slave (
        input  keys,
        output button, bstate, readInput, keyStrobe, chordErr
    );
endinterface

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - 12-key debouncer/encoder with chord rejection; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_CYCLES   = 6000000
) (
    input  logic               hwclk,
    input  logic               reset,
    keypad_debouncer_if.slave  kp
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, RELEASE_DB, TRAIL} state_t;

    state_t        state, state_nxt;
    logic [11:0]   sync1, ks, ks_prev;
    logic [CW-1:0] cnt;
    logic [11:0]   key_pat, key_pat_nxt;
    logic          chord_lock, chord_lock_nxt;
    logic [3:0]    button_r, button_nxt;
    logic          bstate_r, bstate_nxt;
    logic          read_r, read_nxt;
    logic          strobe_r, strobe_nxt;
    logic          chord_r, chord_nxt;
    logic          ks_none, ks_single, reach;
    logic [3:0]    ks_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rpt, rpt_nxt;
`endif

    assign kp.button    = button_r;
    assign kp.bstate    = bstate_r;
    assign kp.readInput = read_r;
    assign kp.keyStrobe = strobe_r;
    assign kp.chordErr  = chord_r;

    // Two-flop synchronizer plus stability counter that restarts on any ks change
    always_ff @(posedge hwclk) begin
        if (reset) begin
            sync1   <= '0;
            ks      <= '0;
            ks_prev <= '0;
            cnt     <= '0;
        end else begin
            sync1   <= kp.keys;
            ks      <= sync1;
            ks_prev <= ks;
            if (ks != ks_prev)
                cnt <= '0;
            else if (cnt != CW'(DEBOUNCE_CYCLES))
                cnt <= cnt + 1'b1;
        end
    end

    // Pattern classification and key encoding of the synchronized lines
    always_comb begin
        ks_none   = (ks == '0);
        ks_single = !ks_none && ((ks & (ks - 12'd1)) == '0);
        // Fires only on the cycle the counter steps onto its limit, so a
        // saturated counter never re-triggers and a ks change always wins.
        reach     = (ks == ks_prev) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
        ks_code   = 4'hF;
        for (int k = 0; k < 12; k++)
            if (ks[k]) ks_code = 4'(k);
    end

    // State and output registers
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state      <= IDLE;
            key_pat    <= '0;
            chord_lock <= 1'b0;
            button_r   <= 4'hF;
            bstate_r   <= 1'b0;
            read_r     <= 1'b0;
            strobe_r   <= 1'b0;
            chord_r    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            key_pat    <= key_pat_nxt;
            chord_lock <= chord_lock_nxt;
            button_r   <= button_nxt;
            bstate_r   <= bstate_nxt;
            read_r     <= read_nxt;
            strobe_r   <= strobe_nxt;
            chord_r    <= chord_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt        <= rpt_nxt;
`endif
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt      = state;
        key_pat_nxt    = key_pat;
        chord_lock_nxt = chord_lock;
        button_nxt     = button_r;
        bstate_nxt     = bstate_r;
        read_nxt       = read_r;
        strobe_nxt     = 1'b0;
        chord_nxt      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_nxt        = '0;
`endif
        case (state)
            // IDLE shares the press path so a pattern that settled while
            // passing through TRAIL/IDLE is still accepted on time.
            IDLE, PRESS_DB: begin
                if (ks_none) begin
                    state_nxt      = IDLE;
                    chord_lock_nxt = 1'b0;
                end else if (reach && ks_single && !chord_lock) begin
                    state_nxt   = HELD;
                    key_pat_nxt = ks;
                    button_nxt  = ks_code;
                    bstate_nxt  = 1'b1;
                    read_nxt    = 1'b1;
                    strobe_nxt  = 1'b1;
                end else if (reach && !ks_single) begin
                    // A rejected chord locks out acceptance until all keys lift
                    state_nxt      = PRESS_DB;
                    chord_nxt      = 1'b1;
                    chord_lock_nxt = 1'b1;
                end else begin
                    state_nxt = PRESS_DB;
                end
            end
            HELD: begin
                if (ks != key_pat) begin
                    state_nxt = RELEASE_DB;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rpt == RW'(REPEAT_CYCLES - 1))
                        strobe_nxt = 1'b1;
                    else
                        rpt_nxt = rpt + 1'b1;
`endif
                end
            end
            RELEASE_DB: begin
                if (ks == key_pat) begin
                    state_nxt = HELD;
                end else if (ks_none && reach) begin
                    state_nxt  = TRAIL;
                    bstate_nxt = 1'b0;
                end
            end
            TRAIL: begin
                state_nxt = IDLE;
                read_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - scoreboard bench for keypad_debouncer
module tb_keypad_debouncer;
    localparam int DC  = 4;
    localparam int LAT = 2 + DC + 1;

    localparam int K_PRESS = 0;
    localparam int K_CHORD = 1;
    localparam int K_REL   = 2;
    localparam int K_RDF   = 3;
    localparam int K_NONE  = 15;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] btn;
    } ev_t;

    logic hwclk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];
    logic bs_q = 1'b0;
    logic ri_q = 1'b0;

    keypad_debouncer_if kp ();

    keypad_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_CYCLES   (20)
    ) dut (
        .hwclk (hwclk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input logic [3:0] btn);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.btn  = btn;
        q.push_back(e);
    endtask

    task automatic got(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", kind, K_NONE);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_button", kp.button, e.btn);
            if (kind == K_PRESS) begin
                chk("press_bstate", kp.bstate, 1);
                chk("press_readInput", kp.readInput, 1);
            end
        end
    endtask

    always @(negedge hwclk) begin
        if (kp.keyStrobe === 1'b1) got(K_PRESS);
        if (kp.chordErr === 1'b1) got(K_CHORD);
        if (bs_q && kp.bstate === 1'b0) got(K_REL);
        if (ri_q && kp.readInput === 1'b0) got(K_RDF);
        bs_q = (kp.bstate === 1'b1);
        ri_q = (kp.readInput === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
    endtask

    task automatic set_keys(input logic [11:0] v);
        @(posedge hwclk);
        #1;
        kp.keys = v;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge hwclk);
            n++;
        end
        #1;
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic press_release(input logic [11:0] v, input logic [3:0] code, input int hold);
        set_keys(v);
        expect_ev(K_PRESS, cyc + LAT, code);
        drain(20);
        tick(hold);
        set_keys(12'h000);
        expect_ev(K_REL, cyc + LAT, code);
        expect_ev(K_RDF, cyc + LAT + 1, code);
        drain(20);
        chk("button_holds", kp.button, code);
    endtask

    initial begin
        kp.keys = 12'h000;
        tick(3);
        @(negedge hwclk);
        chk("rst_button", kp.button, 4'hF);
        chk("rst_bstate", kp.bstate, 0);
        chk("rst_readInput", kp.readInput, 0);
        chk("rst_keyStrobe", kp.keyStrobe, 0);
        chk("rst_chordErr", kp.chordErr, 0);
        @(posedge hwclk);
        #1;
        reset = 1'b0;
        tick(10);
        #1;
        chk("idle_button", kp.button, 4'hF);
        chk("idle_bstate", kp.bstate, 0);

        press_release(12'h100, 4'd8, 8);

        for (int i = 0; i < 10; i++) begin
            set_keys((i % 2 == 0) ? 12'h200 : 12'h000);
            tick(1);
        end
        press_release(12'h200, 4'd9, 5);

        set_keys(12'h180);
        expect_ev(K_CHORD, cyc + LAT, 4'd9);
        drain(20);
        tick(5);
        chk("chord_bstate", kp.bstate, 0);
        chk("chord_button", kp.button, 4'd9);
        set_keys(12'h000);
        tick(12);

        set_keys(12'h080);
        expect_ev(K_PRESS, cyc + LAT, 4'd7);
        drain(20);
        tick(3);
        @(posedge hwclk);
        #1;
        reset = 1'b1;
        expect_ev(K_REL, cyc + 1, 4'hF);
        expect_ev(K_RDF, cyc + 1, 4'hF);
        drain(5);
        chk("midrst_button", kp.button, 4'hF);
        chk("midrst_readInput", kp.readInput, 0);
        tick(2);
        @(posedge hwclk);
        #1;
        reset = 1'b0;
        expect_ev(K_PRESS, cyc + LAT, 4'd7);
        drain(20);
        tick(3);
        set_keys(12'h000);
        expect_ev(K_REL, cyc + LAT, 4'd7);
        expect_ev(K_RDF, cyc + LAT + 1, 4'd7);
        drain(20);

`ifdef KEYPAD_REPEAT_EN
        begin
            int c0;
            set_keys(12'h008);
            c0 = cyc;
            expect_ev(K_PRESS, c0 + LAT, 4'd3);
            expect_ev(K_PRESS, c0 + LAT + 20, 4'd3);
            expect_ev(K_PRESS, c0 + LAT + 40, 4'd3);
            drain(60);
            tick(9);
            #1;
            chk("repeat_bstate", kp.bstate, 1);
            set_keys(12'h000);
            expect_ev(K_REL, cyc + LAT, 4'd3);
            expect_ev(K_RDF, cyc + LAT + 1, 4'd3);
            drain(20);
        end
`endif

        tick(5);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
- Upstream stage of the length checker. Conditions the raw keypad lines and drives its `button`, `bstate` and `readInput` inputs.
- Debounces 12 active-high key lines and rejects multi-key chords.
- Encodes the pressed key to a 4-bit code and produces a debounced press level, plus a qualifying read flag that stays valid across the release edge.
- Runs on `hwclk`. The downstream stage samples on the falling edge of `bstate`, so `button` and `readInput` must be stable around that edge.

Parameters:
- DEBOUNCE_CYCLES, 12000, number of consecutive stable `hwclk` cycles before a press or release is accepted (1 ms at 12 MHz); minimum 2.
- REPEAT_CYCLES, 6000000, hold time before and between auto-repeat pulses; used only with KEYPAD_REPEAT_EN.

Ports:
- hwclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- keys  in  12  raw key lines, active-high; bit k is key code k (0-9 digits, 10 `*`, 11 `#`). Asynchronous to `hwclk`.
- button  out  4  code of the last accepted key; 4'hF = none.
- bstate  out  1  debounced press level; high while the accepted key is held.
- readInput  out  1  high from press acceptance until 1 cycle after `bstate` falls.
- keyStrobe  out  1  one-cycle pulse on each accepted press.
- chordErr  out  1  one-cycle pulse when a stable multi-key pattern is rejected.

Behaviour:
- Input sync: `keys` passes through a 2-flop synchronizer; all logic below uses the synchronized value `ks`. Latency from a `keys` change to `ks` is 2 cycles.
- Pattern classification: `ks` is "single" when exactly one bit is set, "none" when all bits are 0, "chord" otherwise.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES+1)`. It clears whenever `ks` differs from its previous-cycle value, and saturates at DEBOUNCE_CYCLES.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB, TRAIL.
  - IDLE: `ks` != 0 -> PRESS_DB, counter cleared.
  - PRESS_DB:
    - `ks` changes -> counter restarts.
    - `ks` == 0 -> IDLE.
    - Counter reaches DEBOUNCE_CYCLES with a single pattern -> HELD. That cycle: `button` <= encoded key, `bstate` <= 1, `readInput` <= 1, `keyStrobe` = 1.
    - Counter reaches DEBOUNCE_CYCLES with a chord -> `chordErr` = 1 for one cycle, then remain in PRESS_DB until `ks` == 0. No outputs change.
  - HELD: `ks` != latched key pattern (including release or an added key) -> RELEASE_DB.
  - RELEASE_DB:
    - `ks` returns to the latched pattern -> HELD.
    - `ks` == 0 stable for DEBOUNCE_CYCLES -> TRAIL, `bstate` <= 0.
    - A second key added stays in RELEASE_DB until all keys are released.
  - TRAIL: one cycle with `readInput` still 1; then `readInput` <= 0 -> IDLE.
- `button` holds its value after release; it changes only on the next accepted press.
- Total latency from a clean `keys` edge to `bstate` rising: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Bounce shorter than DEBOUNCE_CYCLES produces no output activity.
- Reset values: `button` = 4'hF, `bstate` = 0, `readInput` = 0, `keyStrobe` = 0, `chordErr` = 0, state = IDLE, counter = 0, synchronizer = 0. Reset mid-press returns to IDLE.
- After reset, a key already held must be seen stable for DEBOUNCE_CYCLES before it is accepted. No press is accepted while reset is high.
- Simultaneous events: reset has priority over everything; a `ks` change has priority over counter expiry in the same cycle.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter counts while the key stays stable.
  - On reaching REPEAT_CYCLES it emits a `keyStrobe` pulse and restarts.
  - `bstate` and `readInput` stay high throughout.
- Not defined: no repeat counter; exactly one `keyStrobe` per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20):
- Reset with `keys`=0 -> `button`=4'hF, all other outputs 0; hold `keys`=12'h000 for 10 cycles -> no activity.
- Press `keys`=12'h100 cleanly -> `bstate`, `readInput` and `keyStrobe` assert 7 cycles later and `button`=8; release -> `bstate` falls 7 cycles after release, `readInput` falls 1 cycle later, `button` stays 8.
- Toggle `keys` bit 9 every 2 cycles for 20 cycles, then hold it -> no outputs during the toggling; a single `keyStrobe` after 7 stable cycles with `button`=9.
- Press `keys`=12'h180 (keys 7 and 8) -> one `chordErr` pulse, `bstate` stays 0, `button` unchanged.
- Assert reset while in HELD with `keys`=12'h080 -> all outputs reset next cycle; key still held -> reaccepted 7 cycles after reset falls.
- With KEYPAD_REPEAT_EN, hold key 3 for 50 cycles past acceptance -> `keyStrobe` pulses at acceptance +20 and +40, `bstate` continuously 1.
